// File: rtl/dh_pkg.sv
// Shared types and widths for the Duck Hunt game-flow control blocks.
package dh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FLY,
    HIT_PAUSE,
    ESC_PAUSE,
    ROUND_END,
    GAME_OVER
  } round_state_t;

  localparam int unsigned FRAME_CNT_W = 10;
  localparam int unsigned BCD_W       = 4;

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter with synchronous load and increment; holds at 99.
module bcd_cnt2
  import dh_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*BCD_W-1:0] load_val,
  input  logic               inc,
  output logic [2*BCD_W-1:0] q
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;

  // Next digits: load wins over increment; increment stops at 99.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      {tens_d, units_d} = load_val;
    end else if (inc && !(tens_q == BCD_W'(9) && units_q == BCD_W'(9))) begin
      if (units_q == BCD_W'(9)) begin
        units_d = '0;
        tens_d  = tens_q + BCD_W'(1);
      end else begin
        units_d = units_q + BCD_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign q = {tens_q, units_q};

endmodule

// File: rtl/ctl_round.sv
// Duck Hunt game-flow controller: ammo, ducks, hits and round tracking.
module ctl_round
  import dh_pkg::*;
#(
  parameter int unsigned AMMO_PER_DUCK   = 3,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned HITS_TO_PASS    = 6,
  parameter int unsigned FLY_FRAMES      = 600,
  parameter int unsigned PAUSE_FRAMES    = 60
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       new_frame,
  input  logic       shot_fired,
  input  logic       hit,
  output logic       duck_spawn,
  output logic       duck_flee,
  output logic       reset_score,
  output logic       game_over,
  output logic [3:0] hits_in_round,
  output logic [3:0] ammo_digit,
  output logic [7:0] round_bcd
);

  localparam logic [3:0]             AMMO_INIT = 4'(AMMO_PER_DUCK);
  localparam logic [3:0]             DUCKS_LIM = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0]             HITS_LIM  = 4'(HITS_TO_PASS);
  localparam logic [FRAME_CNT_W-1:0] FLY_LIM   = FRAME_CNT_W'(FLY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_LIM = FRAME_CNT_W'(PAUSE_FRAMES);

  round_state_t           state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d, frame_inc;
  logic [3:0]             ammo_q, ammo_d, ammo_dec;
  logic [3:0]             duck_q, duck_d;
  logic [3:0]             hits_q, hits_d;
  logic                   spawn_q, spawn_d;
  logic                   flee_q, flee_d;
  logic                   rs_q, rs_d;
  logic                   go_q, go_d;
  logic                   pause_done;
  logic                   round_load, round_inc;

  // Next state and counters; a state change always clears the frame counter,
  // so a new_frame on the transition edge is not counted by the new state.
  always_comb begin
    state_d    = state_q;
    ammo_d     = ammo_q;
    duck_d     = duck_q;
    hits_d     = hits_q;
    round_load = 1'b0;
    round_inc  = 1'b0;
    frame_inc  = frame_q + FRAME_CNT_W'(1);
    ammo_dec   = (shot_fired && ammo_q != '0) ? ammo_q - 4'd1 : ammo_q;
    pause_done = new_frame && (frame_inc == PAUSE_LIM);
    case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d    = LAUNCH;
          round_load = 1'b1;
          hits_d     = '0;
          duck_d     = '0;
        end
      end
      LAUNCH: begin
        state_d = FLY;
        ammo_d  = AMMO_INIT;
        duck_d  = duck_q + 4'd1;
      end
      FLY: begin
        ammo_d = ammo_dec;
        if (hit) begin
          hits_d  = (hits_q == '1) ? hits_q : hits_q + 4'd1;
          state_d = HIT_PAUSE;
        end else if (ammo_dec == '0 || (new_frame && frame_inc == FLY_LIM)) begin
          state_d = ESC_PAUSE;
        end
      end
      HIT_PAUSE, ESC_PAUSE: begin
        if (pause_done) begin
          state_d = (duck_q == DUCKS_LIM) ? ROUND_END : LAUNCH;
        end
      end
      ROUND_END: begin
        if (pause_done) begin
          if (hits_q >= HITS_LIM) begin
            state_d   = LAUNCH;
            round_inc = 1'b1;
            hits_d    = '0;
            duck_d    = '0;
          end else begin
            state_d = GAME_OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      frame_d = '0;
    end else if (new_frame) begin
      frame_d = frame_inc;
    end else begin
      frame_d = frame_q;
    end
  end

  // Registered-output decode from the current and next state.
  always_comb begin
    spawn_d = (state_q == LAUNCH);
    flee_d  = (state_d == ESC_PAUSE);
    rs_d    = start && (state_q == IDLE || state_q == GAME_OVER);
    go_d    = (state_d == GAME_OVER);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      ammo_q  <= '0;
      duck_q  <= '0;
      hits_q  <= '0;
      spawn_q <= 1'b0;
      flee_q  <= 1'b0;
      rs_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      ammo_q  <= ammo_d;
      duck_q  <= duck_d;
      hits_q  <= hits_d;
      spawn_q <= spawn_d;
      flee_q  <= flee_d;
      rs_q    <= rs_d;
      go_q    <= go_d;
    end
  end

  bcd_cnt2 u_round (
    .clk      (clk),
    .rst      (rst),
    .load     (round_load),
    .load_val (8'h01),
    .inc      (round_inc),
    .q        (round_bcd)
  );

  assign duck_spawn    = spawn_q;
  assign duck_flee     = flee_q;
  assign reset_score   = rs_q;
  assign game_over     = go_q;
  assign hits_in_round = hits_q;
  assign ammo_digit    = ammo_q;

endmodule
